// File: rtl/imem_loader_if.sv
// Byte-stream / instruction-memory write bus for imem_loader.
// The slave modport is the loader side; the master modport is the byte source
// and memory/CPU side that talks to it.
interface imem_loader_if #(
    parameter int ADDR_W = 31
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Receives a 16-bit word count (MSB byte first) followed by that many 32-bit
// words (MSB byte first) and writes them to word-aligned addresses 0,4,8,...
// The CPU is held until the whole image has been written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match all data bytes before the CPU is released.
module imem_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 31
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DRAIN, CHK, DONE, ERR} state_t;
`else
    typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, DRAIN, DONE, ERR} state_t;
`endif

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t            state;
    state_t            next_state;
    logic [15:0]       n_words;
    logic [15:0]       len_full;
    logic [15:0]       word_idx;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_word;
    logic              ready;
    logic              accept;
    logic              last_word;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // Byte acceptance is refused during the reset cycle itself.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign ready = reset && (state == LEN_HI || state == LEN_LO ||
                             state == DATA   || state == CHK);
`else
    assign ready = reset && (state == LEN_HI || state == LEN_LO || state == DATA);
`endif

    assign accept    = bus.rx_valid && ready;
    assign len_full  = {n_words[15:8], bus.rx_data};
    assign last_word = (word_idx == n_words - 16'd1);

    assign bus.rx_ready = ready;
    assign bus.wr_en    = wr_en;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
    assign bus.done     = (state == DONE);
    assign bus.error    = (state == ERR);
    assign bus.cpu_hold = (state != DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= LEN_HI;
        else        state <= next_state;
    end

    // Next-state decode; DONE and ERR are terminal until reset.
    always_comb begin
        next_state = state;
        case (state)
            LEN_HI: if (accept) next_state = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (len_full == 16'd0)                next_state = DRAIN;
                    else if ({1'b0, len_full} > DEPTH_L)  next_state = ERR;
                    else                                  next_state = DATA;
                end
            end
            DATA: if (accept && byte_cnt == 2'd3 && last_word) next_state = DRAIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
            DRAIN: next_state = CHK;
            CHK: begin
                if (accept) next_state = (bus.rx_data == csum) ? DONE : ERR;
            end
`else
            DRAIN: next_state = DONE;
`endif
            default: next_state = state;
        endcase
    end

    // Length capture, word assembly and the registered memory write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_words  <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            asm_word <= 32'd0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (accept) begin
                case (state)
                    LEN_HI: n_words[15:8] <= bus.rx_data;
                    LEN_LO: n_words[7:0]  <= bus.rx_data;
                    DATA: begin
                        asm_word <= {asm_word[23:0], bus.rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ bus.rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            wr_en    <= 1'b1;
                            wr_data  <= {asm_word[23:0], bus.rx_data};
                            wr_addr  <= ADDR_W'({word_idx, 2'b00});
                            word_idx <= word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader. Honours IMEM_LOADER_CHECKSUM_EN so the
// same bench drives either build.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [7:0]  stream[$];
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    imem_loader_if #(.ADDR_W(31)) bus ();

    imem_loader #(.DEPTH(256), .ADDR_W(31)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wq_addr.push_back({1'b0, bus.wr_addr});
            wq_data.push_back(bus.wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cnt = 0;
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        #1;
        while (bus.rx_ready !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (cnt >= 50) chk("ready_timeout", 32'(cnt), 32'd0);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_stream(input int max_gap);
        foreach (stream[i]) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
            send_byte(stream[i]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_nwr"},   32'(wq_addr.size()), 32'd2);
        chk({tag, "_addr0"}, (wq_addr.size() > 0) ? wq_addr[0] : 32'hDEAD, 32'h0);
        chk({tag, "_data0"}, (wq_data.size() > 0) ? wq_data[0] : 32'hDEAD, 32'h0800_0003);
        chk({tag, "_addr1"}, (wq_addr.size() > 1) ? wq_addr[1] : 32'hDEAD, 32'h4);
        chk({tag, "_data1"}, (wq_data.size() > 1) ? wq_data[1] : 32'hDEAD, 32'h0800_001c);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(negedge clk);
        chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("rst_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
        chk("rst_done",     {31'd0, bus.done},     32'd0);
        chk("rst_error",    {31'd0, bus.error},    32'd0);
        chk("rst_wr_en",    {31'd0, bus.wr_en},    32'd0);
        chk("rst_wr_addr",  {1'b0, bus.wr_addr},   32'd0);
        chk("rst_wr_data",  bus.wr_data,           32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Two-word image at full rate with exact release latency.
        clear_writes();
        stream = {8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h1c};
        send_stream(0);
        @(negedge clk);
        chk("t1_last_wr_en", {31'd0, bus.wr_en}, 32'd1);
        chk("t1_done_early", {31'd0, bus.done},  32'd0);
        chk("t1_drain_rdy",  {31'd0, bus.rx_ready}, 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h1f);
`endif
        @(negedge clk);
        chk("t1_done",     {31'd0, bus.done},     32'd1);
        chk("t1_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        chk("t1_error",    {31'd0, bus.error},    32'd0);
        chk("t1_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("t1_hold_addr", {1'b0, bus.wr_addr},  32'h4);
        chk("t1_hold_data", bus.wr_data,          32'h0800_001c);
        repeat (3) @(negedge clk);
        check_two_writes("t1");

        // Empty image.
        do_reset();
        clear_writes();
        stream = {8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h00);
`endif
        send_stream(0);
        repeat (2) @(negedge clk);
        chk("t2_done",     {31'd0, bus.done},     32'd1);
        chk("t2_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);
        chk("t2_nwr",      32'(wq_addr.size()),   32'd0);

        // Oversized length: 257 words.
        do_reset();
        clear_writes();
        stream = {8'h01, 8'h01};
        send_stream(0);
        @(negedge clk);
        chk("t3_error",    {31'd0, bus.error},    32'd1);
        chk("t3_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
        chk("t3_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        chk("t3_done",     {31'd0, bus.done},     32'd0);
        bus.rx_data  = 8'h55;
        bus.rx_valid = 1'b1;
        repeat (6) @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("t3_nwr",       32'(wq_addr.size()), 32'd0);
        chk("t3_error_hold", {31'd0, bus.error}, 32'd1);

        // Same image with random idle gaps between bytes.
        do_reset();
        clear_writes();
        stream = {8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h1c};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h1f);
`endif
        send_stream(5);
        repeat (3) @(negedge clk);
        chk("t4_done", {31'd0, bus.done}, 32'd1);
        check_two_writes("t4");

        // Reset in the middle of word 1, then a complete reload.
        do_reset();
        clear_writes();
        stream = {8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00};
        send_stream(0);
        repeat (2) @(negedge clk);
        chk("t5_partial_nwr", 32'(wq_addr.size()), 32'd1);
        do_reset();
        chk("t5_rst_addr", {1'b0, bus.wr_addr},   32'd0);
        chk("t5_rst_done", {31'd0, bus.done},     32'd0);
        chk("t5_rst_hold", {31'd0, bus.cpu_hold}, 32'd1);
        clear_writes();
        stream = {8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h1c};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h1f);
`endif
        send_stream(0);
        repeat (3) @(negedge clk);
        chk("t5_done", {31'd0, bus.done}, 32'd1);
        check_two_writes("t5");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum byte.
        do_reset();
        clear_writes();
        stream = {8'h00, 8'h02, 8'h08, 8'h00, 8'h00, 8'h03, 8'h08, 8'h00, 8'h00, 8'h1c, 8'h1e};
        send_stream(0);
        @(negedge clk);
        chk("t6_error",    {31'd0, bus.error},    32'd1);
        chk("t6_done",     {31'd0, bus.done},     32'd0);
        chk("t6_cpu_hold", {31'd0, bus.cpu_hold}, 32'd1);
        check_two_writes("t6");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
